clock_div_multi: RTL and testbench

//   N-channel programmable clock divider, successor to the fixed single-output divider.

---
 rtl/clock_div_multi.sv | 163 ++++++++++++++++
 tb/tb_clock_div_multi.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_multi.sv
// ---------------------------------------------------------------------------
// clock_div_multi
//   N-channel programmable clock divider. Each channel counts system clock
//   cycles against a half-period divisor and toggles its divided clock every
//   `div` enabled cycles, giving a 50% duty output with period 2*div. A tick
//   strobe marks the first cycle of every high phase.
//
//   New divisors arrive through a valid/ready load port into a per-channel
//   shadow register. The shadow only takes effect at the end of a full output
//   period (the high->low wrap), so no output phase is ever cut short. While a
//   shadow is waiting, further loads to that channel are back-pressured.
//
// Ports
//   clk         in   system clock, all state on posedge
//   reset       in   synchronous, active-high; beats every other input
//   en          in   per-channel count enable
//   sync        in   restart all channels phase-aligned, low, at count 0
//   load_valid  in   divisor load request
//   load_ch     in   target channel of the load
//   load_div    in   new half-period divisor (0 is treated as 1)
//   load_ready  out  load accepted on load_valid && load_ready
//   clk_out     out  divided clocks
//   tick        out  one-cycle strobe at each rising edge of clk_out
//   pending     out  channel has a shadow divisor waiting to apply
// ---------------------------------------------------------------------------
module clock_div_multi #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 50,
  localparam int CHW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                load_valid,
  input  logic [CHW-1:0]      load_ch,
  input  logic [WIDTH-1:0]    load_div,
  output logic                load_ready,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  logic [CHANNELS-1:0] ch_match;
  logic [CHANNELS-1:0] ch_accept;
  logic [CHANNELS-1:0] pending_q;
  logic                ch_in_range;
  logic                ch_blocked;
  logic [WIDTH-1:0]    div_clamped;

  // A zero divisor would never wrap; run it as the fastest legal rate.
  assign div_clamped = (load_div == '0) ? WIDTH'(1) : load_div;

  // Channel decode is done by equality per channel rather than a magnitude
  // compare, so an index that cannot address any channel simply matches none.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_match
      assign ch_match[gi] = (load_ch == CHW'(gi));
    end
  endgenerate

  assign ch_in_range = |ch_match;
  assign ch_blocked  = |(ch_match & pending_q);

  // Out-of-range requests are always "accepted" and then dropped.
  assign load_ready  = !ch_in_range || !ch_blocked;
  assign ch_accept   = {CHANNELS{load_valid && load_ready}} & ch_match;
  assign pending     = pending_q;

  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic [WIDTH-1:0] div_q, div_d;
      logic [WIDTH-1:0] shadow_q, shadow_d;
      logic             clk_q, clk_d;
      logic             tick_q, tick_d;
      logic             pend_q, pend_d;
      logic             wrap;

      // div_q is never 0, and cnt restarts at 0 whenever div changes, so a
      // >= compare is equivalent to == here but cannot run away past the end.
      assign wrap = (cnt_q >= (div_q - WIDTH'(1)));

      always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        pend_d   = pend_q;

        if (sync) begin
          // Phase-align restart; whatever divisor is queued takes effect now.
          cnt_d = '0;
          clk_d = 1'b0;
          if (ch_accept[gi]) begin
            div_d    = div_clamped;
            shadow_d = div_clamped;
            pend_d   = 1'b0;
          end else if (pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
          end
        end else begin
          if (en[gi]) begin
            if (wrap) begin
              cnt_d = '0;
              clk_d = ~clk_q;
              if (!clk_q) begin
                tick_d = 1'b1;
              end else if (pend_q) begin
                // End of a full period: the low phase starting now uses the
                // new divisor.
                div_d  = shadow_q;
                pend_d = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + WIDTH'(1);
            end
          end else if (pend_q) begin
            // Stopped channel: nothing to protect, apply straight away. The
            // held phase then lasts the new div from here, never less.
            div_d  = shadow_q;
            pend_d = 1'b0;
            cnt_d  = '0;
          end

          // ch_accept implies pend_q was clear, so this never collides with
          // an apply above.
          if (ch_accept[gi]) begin
            shadow_d = div_clamped;
            pend_d   = 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q    <= '0;
          div_q    <= WIDTH'(DEFAULT_DIV);
          shadow_q <= WIDTH'(DEFAULT_DIV);
          clk_q    <= 1'b0;
          tick_q   <= 1'b0;
          pend_q   <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          div_q    <= div_d;
          shadow_q <= shadow_d;
          clk_q    <= clk_d;
          tick_q   <= tick_d;
          pend_q   <= pend_d;
        end
      end

      assign clk_out[gi]   = clk_q;
      assign tick[gi]      = tick_q;
      assign pending_q[gi] = pend_q;
    end
  endgenerate

endmodule

// File: tb/tb_clock_div_multi.sv
// ---------------------------------------------------------------------------
// tb_clock_div_multi
//   Bench for clock_div_multi with three channels so that a 2-bit load_ch can
//   address a channel that does not exist. A phase-based model (cycles left in
//   the current phase, current level, queued divisor) tracks every channel and
//   is compared against the DUT on every cycle; directed sequences add
//   explicit edge-timing checks on top.
// ---------------------------------------------------------------------------
module tb_clock_div_multi;

  localparam int CH  = 3;
  localparam int W   = 16;
  localparam int DEF = 50;
  localparam int CHW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] en;
  logic          sync;
  logic          load_valid;
  logic [CHW-1:0] load_ch;
  logic [W-1:0]  load_div;
  logic          load_ready;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;
  logic [CH-1:0] pending;

  always #5 clk = ~clk;

  clock_div_multi #(
    .CHANNELS    (CH),
    .WIDTH       (W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sync       (sync),
    .load_valid (load_valid),
    .load_ch    (load_ch),
    .load_div   (load_div),
    .load_ready (load_ready),
    .clk_out    (clk_out),
    .tick       (tick),
    .pending    (pending)
  );

  // ---------------- reference model ----------------
  int m_level [CH];
  int m_remain[CH];
  int m_div   [CH];
  int m_shadow[CH];
  int m_pend  [CH];
  int m_tick  [CH];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic int clampd(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic bit m_ready();
    if (int'(load_ch) >= CH) return 1'b1;
    return (m_pend[int'(load_ch)] == 0);
  endfunction

  function automatic logic [CH-1:0] m_vec(input int sel);
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++)
      v[c] = (sel == 0) ? (m_level[c] != 0) : (sel == 1) ? (m_tick[c] != 0) : (m_pend[c] != 0);
    return v;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < CH; c++) begin
      m_level[c] = 0; m_remain[c] = DEF; m_div[c] = DEF;
      m_shadow[c] = DEF; m_pend[c] = 0; m_tick[c] = 0;
    end
  endtask

  task automatic m_edge(input bit rst, input bit syn, input logic [CH-1:0] e,
                        input bit acc, input int ach, input int adiv);
    if (rst) begin
      m_reset();
      return;
    end
    for (int c = 0; c < CH; c++) begin
      bit mine;
      mine = acc && (ach == c);
      m_tick[c] = 0;
      if (syn) begin
        m_level[c] = 0;
        if (mine) begin
          m_div[c] = clampd(adiv); m_pend[c] = 0;
        end else if (m_pend[c] != 0) begin
          m_div[c] = m_shadow[c]; m_pend[c] = 0;
        end
        m_remain[c] = m_div[c];
      end else begin
        if (e[c]) begin
          m_remain[c]--;
          if (m_remain[c] == 0) begin
            if (m_level[c] == 0) begin
              m_level[c] = 1; m_tick[c] = 1;
            end else begin
              m_level[c] = 0;
              if (m_pend[c] != 0) begin
                m_div[c] = m_shadow[c]; m_pend[c] = 0;
              end
            end
            m_remain[c] = m_div[c];
          end
        end else if (m_pend[c] != 0) begin
          m_div[c] = m_shadow[c]; m_pend[c] = 0; m_remain[c] = m_div[c];
        end
        if (mine) begin
          m_shadow[c] = clampd(adiv); m_pend[c] = 1;
        end
      end
    end
  endtask

  // One clock cycle: check load_ready on the current inputs, clock the DUT and
  // the model, then compare all registered outputs.
  task automatic step();
    bit exp_r, acc;
    int ach, adiv;
    #2;
    exp_r = m_ready();
    chk("load_ready", {31'd0, load_ready}, {31'd0, exp_r});
    acc  = load_valid && exp_r && (int'(load_ch) < CH);
    ach  = int'(load_ch);
    adiv = int'(load_div);
    if (load_valid && exp_r && !reset)
      $display("load ch%0d div=%0d sync=%0b accepted at %0t", ach, adiv, sync, $time);
    @(posedge clk);
    m_edge(reset, sync, en, acc, ach, adiv);
    #1;
    chk("clk_out", {29'd0, clk_out}, {29'd0, m_vec(0)});
    chk("tick",    {29'd0, tick},    {29'd0, m_vec(1)});
    chk("pending", {29'd0, pending}, {29'd0, m_vec(2)});
  endtask

  // Step until clk_out[ch] equals lvl; k = steps taken, or -1 on timeout.
  task automatic wait_level(input int ch, input bit lvl, input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (clk_out[ch] === lvl) begin
        k = i;
        break;
      end
    end
  endtask

  typedef struct {
    int ch;
    int div;
    int exp_rise;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int k, k2, lvl, r0, r1;

    vecs[0] = '{0, 3, 3};
    vecs[1] = '{1, 7, 7};
    vecs[2] = '{2, 0, 1};
    vecs[3] = '{0, 1, 1};
    vecs[4] = '{2, 12, 12};
    vecs[5] = '{1, 2, 2};

    reset = 1'b1; en = '0; sync = 1'b0; load_valid = 1'b0; load_ch = '0; load_div = '0;
    m_reset();
    @(posedge clk); #1;
    step();
    step();
    chk("rst_clk_out", {29'd0, clk_out}, 32'd0);
    chk("rst_tick", {29'd0, tick}, 32'd0);
    chk("rst_pending", {29'd0, pending}, 32'd0);
    chk("rst_ready", {31'd0, load_ready}, 32'd1);

    // T1: default divisor, first rise after 50 cycles with a tick.
    reset = 1'b0; en = '1;
    wait_level(0, 1'b1, 200, k);
    chk("t1_first_rise", k, 50);
    chk("t1_tick", {31'd0, tick[0]}, 32'd1);
    repeat (10) step();

    // T2: load div=3 in the high phase; high phase keeps its 50 cycles.
    load_valid = 1'b1; load_ch = 2'd0; load_div = 16'd3;
    step();
    chk("t2_pending", {31'd0, pending[0]}, 32'd1);
    load_div = 16'd4;
    #1;
    chk("t2_blocked", {31'd0, load_ready}, 32'd0);
    step();
    load_valid = 1'b0;
    wait_level(0, 1'b0, 100, k);
    chk("t2_high_left", k, 38);
    chk("t2_pend_clear", {31'd0, pending[0]}, 32'd0);
    wait_level(0, 1'b1, 20, k);
    chk("t2_low3", k, 3);
    wait_level(0, 1'b0, 20, k);
    chk("t2_high3", k, 3);

    // T3: sync plus load div=0 on ch1 -> toggle every cycle.
    sync = 1'b1; load_valid = 1'b1; load_ch = 2'd1; load_div = 16'd0;
    step();
    chk("t3_sync_low", {29'd0, clk_out}, 32'd0);
    sync = 1'b0; load_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t3_toggle", {31'd0, clk_out[1]}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_tick", {31'd0, tick[1]}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end

    // T4: freeze ch1 for 17 cycles, 4 cycles after a rise, div 9.
    sync = 1'b1; load_valid = 1'b1; load_ch = 2'd1; load_div = 16'd9;
    step();
    sync = 1'b0; load_valid = 1'b0;
    repeat (13) step();
    lvl = int'(clk_out[1]);
    chk("t4_level", lvl, 1);
    en[1] = 1'b0;
    for (int i = 0; i < 17; i++) begin
      step();
      chk("t4_hold", {31'd0, clk_out[1]}, lvl);
      chk("t4_notick", {31'd0, tick[1]}, 32'd0);
    end
    en = '1;
    wait_level(1, 1'b0, 40, k);
    chk("t4_resume", k, 5);

    // T5: div 5 and 7, let them drift with random enables, then sync.
    load_valid = 1'b1; load_ch = 2'd0; load_div = 16'd5;
    step();
    load_ch = 2'd1; load_div = 16'd7;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      en = CH'($urandom);
      step();
    end
    en = '1; sync = 1'b1;
    step();
    chk("t5_sync_low", {30'd0, clk_out[1:0]}, 32'd0);
    sync = 1'b0;
    r0 = -1; r1 = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (r0 < 0 && clk_out[0]) r0 = i;
      if (r1 < 0 && clk_out[1]) r1 = i;
    end
    chk("t5_rise5", r0, 5);
    chk("t5_rise7", r1, 7);

    // T6: reset with a pending load and an out-of-range load_ch.
    load_valid = 1'b1; load_ch = 2'd0; load_div = 16'd9;
    step();
    chk("t6_pending", {31'd0, pending[0]}, 32'd1);
    reset = 1'b1; load_ch = 2'd3; load_div = 16'd20;
    step();
    chk("t6_clk_out", {29'd0, clk_out}, 32'd0);
    chk("t6_tick", {29'd0, tick}, 32'd0);
    chk("t6_pend", {29'd0, pending}, 32'd0);
    chk("t6_ready", {31'd0, load_ready}, 32'd1);
    reset = 1'b0;
    step();
    chk("t6_oor_nochange", {29'd0, pending}, 32'd0);
    load_valid = 1'b0;
    wait_level(0, 1'b1, 200, k2);
    chk("t6_default_div", k2 + 1, 50);

    // Table: sync-with-load applies the divisor directly.
    foreach (vecs[i]) begin
      sync = 1'b1; load_valid = 1'b0;
      step();
      load_valid = 1'b1; load_ch = CHW'(vecs[i].ch); load_div = W'(vecs[i].div);
      step();
      sync = 1'b0; load_valid = 1'b0;
      wait_level(vecs[i].ch, 1'b1, 100, k);
      $display("vector %0d: ch%0d div=%0d first rise after %0d cycles", i, vecs[i].ch, vecs[i].div, k);
      chk("vec_rise", k, vecs[i].exp_rise);
      chk("vec_tick", {31'd0, tick[vecs[i].ch]}, 32'd1);
    end

    // Random phase against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) en[c] = ($urandom_range(0, 7) != 0);
      sync       = ($urandom_range(0, 79) == 0);
      reset      = ($urandom_range(0, 499) == 0);
      load_valid = ($urandom_range(0, 5) == 0);
      load_ch    = CHW'($urandom_range(0, 3));
      load_div   = W'($urandom_range(0, 9));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
